pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_W, default 5, register-specifier width.
REQ-002 SHALL have parameter TIMEOUT, default 64, the maximum number of MEM_WAIT cycles before an error is declared.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have ports id_rs and id_rt, input, REG_W bits each: source registers of the instruction in ID.
REQ-006 SHALL have port id_uses_rt, input, 1 bit: the ID instruction reads rt.
REQ-007 SHALL have ports ex_rd (input, REG_W bits) and ex_memread (input, 1 bit): destination and load flag of the instruction in EX.
REQ-008 SHALL have port branch_taken, input, 1 bit: a branch resolved taken in EX.
REQ-009 SHALL have ports mem_req and mem_ready, input, 1 bit each: the MEM-stage access request and the data-memory completion.
REQ-010 SHALL have outputs pc_en, ifid_en, idex_en, exmem_en and memwb_en, 1 bit each: hold/advance enables for the pipeline registers.
REQ-011 SHALL have outputs ifid_flush and idex_flush, 1 bit each: force the bubble (zero) value into IF/ID or ID/EX on the next edge.
REQ-012 SHALL have output mem_error, 1 bit: sticky flag indicating a memory timeout.
REQ-013 SHALL have output stall_cnt, 16 bits: saturating count of cycles in which pc_en was 0.

Function
REQ-014 SHALL implement the FSM states RUN, MEM_WAIT and RESUME.
REQ-015 SHALL define load_use = ex_memread & (ex_rd != 0) & ((ex_rd == id_rs) | (id_uses_rt & ex_rd == id_rt)).
REQ-016 In RUN with mem_req & !mem_ready, SHALL drive all five enables to 0 and both flushes to 0, and go to MEM_WAIT.
REQ-017 In RUN with mem_req & mem_ready at the same time, SHALL not stall and SHALL stay in RUN.
REQ-018 In RUN with no memory stall and branch_taken=1, SHALL drive all enables to 1 and ifid_flush=idex_flush=1 for one cycle.
REQ-019 In RUN with no memory stall, branch_taken=0 and load_use=1, SHALL drive pc_en=ifid_en=0, idex_flush=1 and the other enables to 1, giving a one-cycle bubble.
REQ-020 SHALL apply the priority memory stall > branch flush > load-use; when branch_taken and load_use are both 1, only the branch flush applies.
REQ-021 In RUN with no event, SHALL drive all enables to 1 and all flushes to 0.
REQ-022 In MEM_WAIT, SHALL hold all enables at 0 and all flushes at 0.
REQ-023 In MEM_WAIT, SHALL increment a wait counter by 1 per cycle.
REQ-024 In MEM_WAIT, on mem_ready=1 SHALL go to RESUME.
REQ-025 In MEM_WAIT, when the wait counter reaches TIMEOUT-1 without mem_ready, SHALL set mem_error=1 and go to RESUME.
REQ-026 In RESUME, SHALL evaluate outputs exactly as RUN except that mem_req is ignored, and SHALL return to RUN after one cycle.
REQ-027 SHALL clear the wait counter on every entry to MEM_WAIT.
REQ-028 SHALL hold mem_error at 1 until reset.
REQ-029 SHALL increment stall_cnt in every cycle with pc_en=0 and saturate it at 16'hFFFF with no wrap.
REQ-030 Enables and flushes SHALL be combinational from the state and the inputs; all other outputs SHALL be registered.

Reset
REQ-031 While reset=0, SHALL force state to RUN, the wait counter to 0, mem_error to 0 and stall_cnt to 0, immediately and independent of clk.
REQ-032 While reset=0, SHALL drive all enables to 0, all flushes to 0, mem_error to 0 and stall_cnt to 0.
REQ-033 Deassertion of reset SHALL take effect at the next rising edge of clk.
REQ-034 Reset asserted in MEM_WAIT SHALL abandon the wait with no error recorded.

Structure
REQ-035 SHALL place the state enum (RUN, MEM_WAIT, RESUME) and the default REG_W in a shared package, pipeline_pkg.
REQ-036 SHALL implement the stall counter as sub-module sat_counter16, with ports clk, reset, inc and count.
REQ-037 SHALL contain no storage other than the state, the wait counter, mem_error and sat_counter16.

Verification
REQ-038 Load-use: ex_memread=1, ex_rd=5, id_rs=5 -> pc_en=0, ifid_en=0, idex_flush=1 for one cycle; stall_cnt=1.
REQ-039 Register zero: ex_memread=1, ex_rd=0, id_rs=0 -> no stall, all enables 1.
REQ-040 Branch and load-use together: branch_taken=1 with a load-use match -> both flushes 1, all enables 1, stall_cnt unchanged.
REQ-041 Memory wait: mem_req=1 with mem_ready low for 3 cycles, then high -> enables 0 for 3 cycles, MEM_WAIT exits, RESUME lasts 1 cycle, stall_cnt=3.
REQ-042 Timeout: mem_req=1 with mem_ready never asserted and TIMEOUT=4 -> mem_error=1 after 4 wait cycles, FSM reaches RESUME, mem_error stays 1 until reset.
REQ-043 Reset mid-wait: reset pulled low in MEM_WAIT -> outputs clear immediately; after release, FSM is in RUN with mem_error=0 and stall_cnt=0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared types and control-word helpers for the hazard controller
// Contents: state_t (RUN, MEM_WAIT, RESUME), DEFAULT_REG_W, ctrl_t enable/flush
// bundle, and run_ctrl() which resolves RUN-state hazards by priority.
package pipeline_pkg;

  localparam int DEFAULT_REG_W = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    RESUME   = 2'd2
  } state_t;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
  } ctrl_t;

  localparam ctrl_t CTRL_HOLD   = 7'b00000_00;
  localparam ctrl_t CTRL_RUN    = 7'b11111_00;
  localparam ctrl_t CTRL_BRANCH = 7'b11111_11;
  // Freeze PC and IF/ID, push a bubble into ID/EX, let the older stages drain.
  localparam ctrl_t CTRL_BUBBLE = 7'b00111_01;

  // Priority: memory stall > branch flush > load-use bubble.
  function automatic ctrl_t run_ctrl(input logic mem_stall,
                                     input logic branch_taken,
                                     input logic load_use);
    ctrl_t c;
    if (mem_stall)         c = CTRL_HOLD;
    else if (branch_taken) c = CTRL_BRANCH;
    else if (load_use)     c = CTRL_BUBBLE;
    else                   c = CTRL_RUN;
    return c;
  endfunction

endpackage

// File: rtl/sat_counter16.sv
// rtl/sat_counter16.sv - 16-bit up counter that saturates at 16'hFFFF
// Ports: clk, reset (async active-low), inc (count enable), count (registered value).
module sat_counter16 (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  output logic [15:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && (count != 16'hFFFF)) begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - pipeline stall/flush controller with memory-wait FSM
// Inputs: clk, reset (async active-low), id_rs/id_rt/id_uses_rt (ID sources),
//   ex_rd/ex_memread (EX load), branch_taken, mem_req/mem_ready (MEM access).
// Outputs: pc_en, ifid_en, idex_en, exmem_en, memwb_en (combinational enables),
//   ifid_flush, idex_flush (combinational bubbles), mem_error (sticky timeout),
//   stall_cnt (saturating count of cycles with pc_en low).
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int REG_W   = DEFAULT_REG_W,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_memread,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             mem_error,
  output logic [15:0]      stall_cnt
);

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              load_use;
  logic              mem_stall;
  ctrl_t             ctrl;

  // Register zero is hard-wired, so a load targeting it never creates a hazard.
  assign load_use = ex_memread && (ex_rd != '0) &&
                    ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

  // RESUME ignores mem_req so the access that just completed is not re-stalled.
  assign mem_stall = (state == RUN) && mem_req && !mem_ready;

  always_comb begin
    ctrl = CTRL_HOLD;
    case (state)
      RUN, RESUME: ctrl = run_ctrl(mem_stall, branch_taken, load_use);
      default:     ctrl = CTRL_HOLD;
    endcase
    if (!reset) ctrl = CTRL_HOLD;
  end

  assign pc_en      = ctrl.pc_en;
  assign ifid_en    = ctrl.ifid_en;
  assign idex_en    = ctrl.idex_en;
  assign exmem_en   = ctrl.exmem_en;
  assign memwb_en   = ctrl.memwb_en;
  assign ifid_flush = ctrl.ifid_flush;
  assign idex_flush = ctrl.idex_flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      wait_cnt  <= '0;
      mem_error <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (mem_stall) begin
            state    <= MEM_WAIT;
            wait_cnt <= '0;
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            state <= RESUME;
          end else if (wait_cnt == WAIT_LAST) begin
            mem_error <= 1'b1;
            state     <= RESUME;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESUME:  state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  sat_counter16 u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (!pc_en),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  id_rs = '0;
  logic [4:0]  id_rt = '0;
  logic        id_uses_rt = 1'b0;
  logic [4:0]  ex_rd = '0;
  logic        ex_memread = 1'b0;
  logic        branch_taken = 1'b0;
  logic        mem_req = 1'b0;
  logic        mem_ready = 1'b0;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_flush, mem_error;
  logic [15:0] stall_cnt;

  int checks = 0;
  int failures = 0;

  wire [4:0] en = {pc_en, ifid_en, idex_en, exmem_en, memwb_en};
  wire [1:0] fl = {ifid_flush, idex_flush};

  pipeline_hazard_ctrl #(.REG_W(5), .TIMEOUT(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .ex_rd        (ex_rd),
    .ex_memread   (ex_memread),
    .branch_taken (branch_taken),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .pc_en        (pc_en),
    .ifid_en      (ifid_en),
    .idex_en      (idex_en),
    .exmem_en     (exmem_en),
    .memwb_en     (memwb_en),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .mem_error    (mem_error),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; ex_rd = '0; ex_memread = 1'b0;
    branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (en !== 5'b00000) begin failures++; $display("FAIL reset_en got=%b exp=00000", en); end
    checks++; if (fl !== 2'b00) begin failures++; $display("FAIL reset_flush got=%b exp=00", fl); end
    checks++; if (mem_error !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", mem_error); end
    checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", stall_cnt); end
    reset = 1'b1;
    next_cycle();
  endtask

  task automatic test_idle();
    idle_inputs(); #3;
    checks++; if (en !== 5'b11111 || fl !== 2'b00) begin failures++; $display("FAIL idle got=%b/%b exp=11111/00", en, fl); end
    next_cycle();
    checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL idle_cnt got=%0d exp=0", stall_cnt); end
  endtask

  task automatic test_load_use();
    ex_memread = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; #3;
    checks++; if (en !== 5'b00111 || fl !== 2'b01) begin failures++; $display("FAIL load_use_rs got=%b/%b exp=00111/01", en, fl); end
    next_cycle(); idle_inputs(); #3;
    checks++; if (en !== 5'b11111) begin failures++; $display("FAIL load_use_one_cycle got=%b exp=11111", en); end
    checks++; if (stall_cnt !== 16'd1) begin failures++; $display("FAIL load_use_cnt got=%0d exp=1", stall_cnt); end
    ex_memread = 1'b1; ex_rd = 5'd7; id_rs = 5'd3; id_rt = 5'd7; id_uses_rt = 1'b1; #1;
    checks++; if (en !== 5'b00111 || fl !== 2'b01) begin failures++; $display("FAIL load_use_rt got=%b/%b exp=00111/01", en, fl); end
    next_cycle();
    id_uses_rt = 1'b0; #3;
    checks++; if (en !== 5'b11111 || fl !== 2'b00) begin failures++; $display("FAIL rt_unused got=%b/%b exp=11111/00", en, fl); end
    checks++; if (stall_cnt !== 16'd2) begin failures++; $display("FAIL load_use_rt_cnt got=%0d exp=2", stall_cnt); end
    next_cycle();
  endtask

  task automatic test_reg_zero();
    idle_inputs(); ex_memread = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b1; #3;
    checks++; if (en !== 5'b11111 || fl !== 2'b00) begin failures++; $display("FAIL reg_zero got=%b/%b exp=11111/00", en, fl); end
    next_cycle();
  endtask

  task automatic test_branch_load_use();
    idle_inputs(); ex_memread = 1'b1; ex_rd = 5'd9; id_rs = 5'd9; branch_taken = 1'b1; #3;
    checks++; if (en !== 5'b11111 || fl !== 2'b11) begin failures++; $display("FAIL branch_lu got=%b/%b exp=11111/11", en, fl); end
    next_cycle(); idle_inputs(); #3;
    checks++; if (stall_cnt !== 16'd2) begin failures++; $display("FAIL branch_lu_cnt got=%0d exp=2", stall_cnt); end
    next_cycle();
  endtask

  task automatic test_mem_wait();
    idle_inputs(); mem_req = 1'b1; #3;
    checks++; if (en !== 5'b00000 || fl !== 2'b00) begin failures++; $display("FAIL mw_enter got=%b/%b exp=00000/00", en, fl); end
    next_cycle(); #3;
    checks++; if (en !== 5'b00000) begin failures++; $display("FAIL mw_wait1 got=%b exp=00000", en); end
    next_cycle(); mem_ready = 1'b1; #3;
    checks++; if (en !== 5'b00000 || fl !== 2'b00) begin failures++; $display("FAIL mw_wait_ready got=%b/%b exp=00000/00", en, fl); end
    next_cycle(); mem_ready = 1'b0; #3;
    checks++; if (en !== 5'b11111) begin failures++; $display("FAIL mw_resume got=%b exp=11111", en); end
    checks++; if (stall_cnt !== 16'd5) begin failures++; $display("FAIL mw_cnt got=%0d exp=5", stall_cnt); end
    next_cycle(); #3;
    checks++; if (en !== 5'b00000) begin failures++; $display("FAIL mw_back_in_run got=%b exp=00000", en); end
    next_cycle(); mem_ready = 1'b1; mem_req = 1'b0;
    next_cycle(); idle_inputs(); #3;
    checks++; if (stall_cnt !== 16'd7) begin failures++; $display("FAIL mw_cnt2 got=%0d exp=7", stall_cnt); end
    next_cycle();
    mem_req = 1'b1; mem_ready = 1'b1; #3;
    checks++; if (en !== 5'b11111) begin failures++; $display("FAIL mw_ready_same_cycle got=%b exp=11111", en); end
    next_cycle(); mem_ready = 1'b0; #3;
    checks++; if (en !== 5'b00000) begin failures++; $display("FAIL mw_stayed_run got=%b exp=00000", en); end
    next_cycle(); mem_ready = 1'b1; mem_req = 1'b0;
    next_cycle(); idle_inputs(); #3;
    checks++; if (stall_cnt !== 16'd9) begin failures++; $display("FAIL mw_cnt3 got=%0d exp=9", stall_cnt); end
    next_cycle();
  endtask

  task automatic test_timeout();
    idle_inputs(); mem_req = 1'b1;
    next_cycle();
    for (int w = 1; w <= 4; w++) begin
      #3;
      checks++; if (mem_error !== 1'b0 || en !== 5'b00000) begin failures++; $display("FAIL to_wait%0d err=%b en=%b exp=0/00000", w, mem_error, en); end
      next_cycle();
    end
    #3;
    checks++; if (mem_error !== 1'b1) begin failures++; $display("FAIL to_err got=%b exp=1", mem_error); end
    checks++; if (en !== 5'b11111) begin failures++; $display("FAIL to_resume got=%b exp=11111", en); end
    checks++; if (stall_cnt !== 16'd14) begin failures++; $display("FAIL to_cnt got=%0d exp=14", stall_cnt); end
    next_cycle(); mem_req = 1'b0;
    next_cycle(); next_cycle(); #3;
    checks++; if (mem_error !== 1'b1 || en !== 5'b11111) begin failures++; $display("FAIL to_sticky err=%b en=%b exp=1/11111", mem_error, en); end
    next_cycle();
  endtask

  task automatic test_reset_mid_wait();
    idle_inputs(); mem_req = 1'b1;
    next_cycle(); next_cycle(); #2;
    reset = 1'b0; #1;
    checks++; if (en !== 5'b00000 || fl !== 2'b00) begin failures++; $display("FAIL rmw_en got=%b/%b exp=00000/00", en, fl); end
    checks++; if (mem_error !== 1'b0 || stall_cnt !== 16'd0) begin failures++; $display("FAIL rmw_clear err=%b cnt=%0d exp=0/0", mem_error, stall_cnt); end
    idle_inputs();
    next_cycle(); reset = 1'b1;
    next_cycle(); #3;
    checks++; if (en !== 5'b11111 || mem_error !== 1'b0 || stall_cnt !== 16'd0) begin failures++; $display("FAIL rmw_after en=%b err=%b cnt=%0d exp=11111/0/0", en, mem_error, stall_cnt); end
    mem_req = 1'b1; #1;
    checks++; if (en !== 5'b00000) begin failures++; $display("FAIL rmw_run got=%b exp=00000", en); end
    next_cycle(); idle_inputs();
  endtask

  initial begin
    test_reset();
    test_idle();
    test_load_use();
    test_reg_zero();
    test_branch_load_use();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
